xyolo_seq: RTL and testbench

Layer sequencer for the xyolo convolution/activation/maxpool functional unit. It holds a host-writable shadow copy of the xyolo configuration word. On a run request it copies the shadow into an active register that drives the unit, then runs a programmed number of tiles back-to-back. For each tile it pulses the unit's init input and counts the exact number of cycles the unit needs. It reports per-tile and per-layer completion to the controller above.

---
 rtl/xyolo_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_xyolo_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xyolo_seq.sv
// xyolo layer sequencer: host-writable shadow configuration, active copy taken on run,
// and per-tile init strobe plus exact cycle counting for the xyolo unit.
`ifndef N_W
`define N_W 4
`endif
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif
`ifndef PERIOD_W
`define PERIOD_W 8
`endif
`ifndef SHIFT_W
`define SHIFT_W 5
`endif
`ifndef YOLO_CONF_BITS
`define YOLO_CONF_BITS (3*`N_W + `MEM_ADDR_W + 2*`PERIOD_W + `SHIFT_W + 3)
`endif

module xyolo_seq #(
    parameter int DATA_W   = 32,
    parameter int PIPE_LAT = 5,
    parameter int REP_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_addr,
    input  logic [DATA_W-1:0]          cfg_wdata,
    input  logic                       run,
    input  logic                       abort,
    output logic                       busy,
    output logic                       tile_done,
    output logic                       done,
    output logic                       yolo_rst,
    output logic                       yolo_addrgen_rst,
    output logic [`YOLO_CONF_BITS-1:0] yolo_conf
);

    localparam int PROD_W = `MEM_ADDR_W + `PERIOD_W;
    localparam int CNT_W  = PROD_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [`N_W-1:0]        sh_sela_q, sh_selb_q, sh_selc_q;
    logic [`MEM_ADDR_W-1:0] sh_iter_q;
    logic [`PERIOD_W-1:0]   sh_period_q, sh_delay_q;
    logic [`SHIFT_W-1:0]    sh_shift_q;
    logic [2:0]             sh_flags_q;
    logic [REP_W-1:0]       sh_rep_q;

    logic [`N_W-1:0]        act_sela_q, act_selb_q, act_selc_q;
    logic [`MEM_ADDR_W-1:0] act_iter_q;
    logic [`PERIOD_W-1:0]   act_period_q, act_delay_q;
    logic [`SHIFT_W-1:0]    act_shift_q;
    logic [2:0]             act_flags_q;

    logic [CNT_W-1:0]       cnt_q, cnt_d, tile_len_m1;
    logic [REP_W-1:0]       rem_q, rem_d;
    logic [`PERIOD_W-1:0]   period_eff;
    logic [PROD_W-1:0]      prod;
    logic                   load_act, abort_hit;
    logic                   yolo_rst_q, yolo_rst_d;
    logic                   agen_rst_q, agen_rst_d;
    logic                   unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Shadow writes never touch the active copy, so the unit sees a stable config mid-layer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_sela_q   <= '0;
            sh_selb_q   <= '0;
            sh_selc_q   <= '0;
            sh_iter_q   <= '0;
            sh_period_q <= '0;
            sh_delay_q  <= '0;
            sh_shift_q  <= '0;
            sh_flags_q  <= '0;
            sh_rep_q    <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                4'd0:    sh_sela_q   <= cfg_wdata[`N_W-1:0];
                4'd1:    sh_selb_q   <= cfg_wdata[`N_W-1:0];
                4'd2:    sh_selc_q   <= cfg_wdata[`N_W-1:0];
                4'd3:    sh_iter_q   <= cfg_wdata[`MEM_ADDR_W-1:0];
                4'd4:    sh_period_q <= cfg_wdata[`PERIOD_W-1:0];
                4'd5:    sh_delay_q  <= cfg_wdata[`PERIOD_W-1:0];
                4'd6:    sh_shift_q  <= cfg_wdata[`SHIFT_W-1:0];
                4'd7:    sh_flags_q  <= cfg_wdata[2:0];
                4'd8:    sh_rep_q    <= cfg_wdata[REP_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_sela_q   <= '0;
            act_selb_q   <= '0;
            act_selc_q   <= '0;
            act_iter_q   <= '0;
            act_period_q <= '0;
            act_delay_q  <= '0;
            act_shift_q  <= '0;
            act_flags_q  <= '0;
        end else if (load_act) begin
            act_sela_q   <= sh_sela_q;
            act_selb_q   <= sh_selb_q;
            act_selc_q   <= sh_selc_q;
            act_iter_q   <= sh_iter_q;
            act_period_q <= sh_period_q;
            act_delay_q  <= sh_delay_q;
            act_shift_q  <= sh_shift_q;
            act_flags_q  <= sh_flags_q;
        end
    end

    // flags are stored {maxpool,leaky,bias}; the conf word wants bias, leaky, maxpool MSB-first.
    assign yolo_conf = {act_sela_q, act_selb_q, act_selc_q, act_iter_q, act_period_q,
                        act_delay_q, act_shift_q, act_flags_q[0], act_flags_q[1], act_flags_q[2]};

    always_comb begin
        period_eff  = (act_period_q == '0) ? `PERIOD_W'(1) : act_period_q;
        prod        = PROD_W'(act_iter_q) * PROD_W'(period_eff);
        tile_len_m1 = CNT_W'(act_delay_q) + CNT_W'(prod) + CNT_W'(PIPE_LAT) - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_act  = 1'b0;
        abort_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    load_act = 1'b1;
                    state_d  = (sh_iter_q == '0) ? S_DONE : S_INIT;
                end
            end
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:  state_d = (rem_q == REP_W'(1)) ? S_DONE : S_INIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            abort_hit = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        if (load_act) begin
            rem_d = (sh_rep_q == '0) ? REP_W'(1) : sh_rep_q;
        end
        case (state_q)
            S_INIT: cnt_d = tile_len_m1;
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NEXT:  rem_d = rem_q - REP_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end

    // The init strobe is registered off the next state so it lines up with the INIT cycle
    // and with the cycle after an abort, without any combinational path from the inputs.
    always_comb begin
        busy       = (state_q != S_IDLE);
        tile_done  = (state_q == S_NEXT);
        done       = (state_q == S_DONE);
        yolo_rst_d = (state_d == S_INIT) || abort_hit;
        agen_rst_d = abort_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            yolo_rst_q <= 1'b0;
            agen_rst_q <= 1'b1;
        end else begin
            yolo_rst_q <= yolo_rst_d;
            agen_rst_q <= agen_rst_d;
        end
    end

    assign yolo_rst         = yolo_rst_q;
    assign yolo_addrgen_rst = agen_rst_q;

endmodule

// File: tb/tb_xyolo_seq.sv
// Directed self-checking bench for xyolo_seq: reset, tile timing, repeat, abort,
// zero iterations, back-to-back runs and shadow/active isolation.
`timescale 1ns/1ps
`ifndef N_W
`define N_W 4
`endif
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif
`ifndef PERIOD_W
`define PERIOD_W 8
`endif
`ifndef SHIFT_W
`define SHIFT_W 5
`endif
`ifndef YOLO_CONF_BITS
`define YOLO_CONF_BITS (3*`N_W + `MEM_ADDR_W + 2*`PERIOD_W + `SHIFT_W + 3)
`endif

module tb_xyolo_seq;
    logic                       clk;
    logic                       rst;
    logic                       cfg_we;
    logic [3:0]                 cfg_addr;
    logic [31:0]                cfg_wdata;
    logic                       run;
    logic                       abort;
    logic                       busy;
    logic                       tile_done;
    logic                       done;
    logic                       yolo_rst;
    logic                       yolo_addrgen_rst;
    logic [`YOLO_CONF_BITS-1:0] yolo_conf;

    int checks = 0;
    int errors = 0;

    logic [127:0] tr_rst, tr_td, tr_done, tr_busy;
    logic [127:0] e_rst, e_td, e_done, e_busy;
    logic [`YOLO_CONF_BITS-1:0] tr_conf0, exp_conf;
    logic tr_conf_chg;

    xyolo_seq #(.DATA_W(32), .PIPE_LAT(5), .REP_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .run(run), .abort(abort), .busy(busy), .tile_done(tile_done), .done(done),
        .yolo_rst(yolo_rst), .yolo_addrgen_rst(yolo_addrgen_rst), .yolo_conf(yolo_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [3:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_we    = 1'b1;
        step();
        cfg_we    = 1'b0;
    endtask

    function automatic logic [`YOLO_CONF_BITS-1:0] mk_conf(input logic [31:0] sa, sb, sc, it, pe, de, sh, fl);
        logic [`N_W-1:0] a, b, c;
        logic [`MEM_ADDR_W-1:0] i;
        logic [`PERIOD_W-1:0] p, d;
        logic [`SHIFT_W-1:0] s;
        a = sa[`N_W-1:0];
        b = sb[`N_W-1:0];
        c = sc[`N_W-1:0];
        i = it[`MEM_ADDR_W-1:0];
        p = pe[`PERIOD_W-1:0];
        d = de[`PERIOD_W-1:0];
        s = sh[`SHIFT_W-1:0];
        return {a, b, c, i, p, d, s, fl[0], fl[1], fl[2]};
    endfunction

    task automatic program_cfg(input logic [31:0] sa, sb, sc, it, pe, de, sh, fl, rp);
        write_cfg(4'd0, sa);
        write_cfg(4'd1, sb);
        write_cfg(4'd2, sc);
        write_cfg(4'd3, it);
        write_cfg(4'd4, pe);
        write_cfg(4'd5, de);
        write_cfg(4'd6, sh);
        write_cfg(4'd7, fl);
        write_cfg(4'd8, rp);
        exp_conf = mk_conf(sa, sb, sc, it, pe, de, sh, fl);
    endtask

    // Cycle 0 of the trace is the first cycle after the run-accepting edge.
    task automatic trace(input int ncyc, input bit hold_run);
        tr_rst = '0; tr_td = '0; tr_done = '0; tr_busy = '0; tr_conf_chg = 1'b0;
        run = 1'b1;
        step();
        cfg_we = 1'b0;
        if (!hold_run) run = 1'b0;
        tr_conf0 = yolo_conf;
        for (int c = 0; c < ncyc; c++) begin
            tr_rst[c]  = yolo_rst;
            tr_td[c]   = tile_done;
            tr_done[c] = done;
            tr_busy[c] = busy;
            if (busy && (yolo_conf !== tr_conf0)) tr_conf_chg = 1'b1;
            if (c == ncyc - 1) run = 1'b0;
            step();
        end
    endtask

    // tile_cyc is the hand-computed tile cost L+2.
    task automatic build_exp(input int tile_cyc, input int ntiles, input bit zero_it);
        e_rst = '0; e_td = '0; e_done = '0; e_busy = '0;
        if (zero_it) begin
            e_busy[0] = 1'b1;
            e_done[0] = 1'b1;
        end else begin
            for (int t = 0; t < ntiles; t++) begin
                e_rst[t*tile_cyc] = 1'b1;
                e_td[t*tile_cyc + tile_cyc - 1] = 1'b1;
            end
            e_done[ntiles*tile_cyc] = 1'b1;
            for (int i = 0; i <= ntiles*tile_cyc; i++) e_busy[i] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) write_cfg(4'($urandom_range(0, 8)), $urandom);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d: got %b want 0", i, busy); end
            checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL reset_tile_done c%0d: got %b want 0", i, tile_done); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done c%0d: got %b want 0", i, done); end
            checks++; if (yolo_rst !== 1'b0) begin errors++; $display("FAIL reset_yolo_rst c%0d: got %b want 0", i, yolo_rst); end
            checks++; if (yolo_addrgen_rst !== 1'b1) begin errors++; $display("FAIL reset_agen c%0d: got %b want 1", i, yolo_addrgen_rst); end
            checks++; if (yolo_conf !== '0) begin errors++; $display("FAIL reset_conf c%0d: got %h want 0", i, yolo_conf); end
        end
        rst = 1'b0;
        step();
        checks++; if (yolo_addrgen_rst !== 1'b0) begin errors++; $display("FAIL post_reset_agen: got %b want 0", yolo_addrgen_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        // Cleared shadow has iterations 0, so a run goes straight to DONE.
        build_exp(1, 1, 1'b1);
        trace(3, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done, tr_busy} !== {e_rst, e_td, e_done, e_busy}) begin errors++; $display("FAIL reset_run_trace: got %h want %h", {tr_rst, tr_td, tr_done, tr_busy}, {e_rst, e_td, e_done, e_busy}); end
        checks++; if (tr_conf0 !== '0) begin errors++; $display("FAIL reset_run_conf: got %h want 0", tr_conf0); end
    endtask

    task automatic test_single_tile();
        program_cfg(1, 2, 3, 4, 3, 2, 5, 5, 1);
        build_exp(21, 1, 1'b0);  // L = 2 + 4*3 + 5 = 19
        trace(26, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done} !== {e_rst, e_td, e_done}) begin errors++; $display("FAIL single_pulses: got %h want %h", {tr_rst, tr_td, tr_done}, {e_rst, e_td, e_done}); end
        checks++; if (tr_busy !== e_busy) begin errors++; $display("FAIL single_busy: got %h want %h", tr_busy, e_busy); end
        checks++; if ({tr_conf0, tr_conf_chg} !== {exp_conf, 1'b0}) begin errors++; $display("FAIL single_conf: got %h/%b want %h/0", tr_conf0, tr_conf_chg, exp_conf); end
    endtask

    task automatic test_repeat();
        program_cfg(1, 2, 3, 4, 3, 2, 5, 5, 3);
        build_exp(21, 3, 1'b0);
        trace(68, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done} !== {e_rst, e_td, e_done}) begin errors++; $display("FAIL repeat3_pulses: got %h want %h", {tr_rst, tr_td, tr_done}, {e_rst, e_td, e_done}); end
        checks++; if (tr_busy !== e_busy) begin errors++; $display("FAIL repeat3_busy: got %h want %h", tr_busy, e_busy); end
        checks++; if ({tr_conf0, tr_conf_chg} !== {exp_conf, 1'b0}) begin errors++; $display("FAIL repeat3_conf: got %h/%b want %h/0", tr_conf0, tr_conf_chg, exp_conf); end
    endtask

    task automatic test_repeat_zero();
        program_cfg(4, 5, 6, 4, 3, 2, 1, 2, 0);
        build_exp(21, 1, 1'b0);
        trace(26, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done} !== {e_rst, e_td, e_done}) begin errors++; $display("FAIL repeat0_pulses: got %h want %h", {tr_rst, tr_td, tr_done}, {e_rst, e_td, e_done}); end
        checks++; if (tr_busy !== e_busy) begin errors++; $display("FAIL repeat0_busy: got %h want %h", tr_busy, e_busy); end
        checks++; if ({tr_conf0, tr_conf_chg} !== {exp_conf, 1'b0}) begin errors++; $display("FAIL repeat0_conf: got %h/%b want %h/0", tr_conf0, tr_conf_chg, exp_conf); end
    endtask

    task automatic test_period_zero();
        program_cfg(7, 0, 9, 4, 0, 2, 31, 1, 1);
        build_exp(13, 1, 1'b0);  // period 0 counts as 1: L = 2 + 4 + 5 = 11
        trace(18, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done} !== {e_rst, e_td, e_done}) begin errors++; $display("FAIL period0_pulses: got %h want %h", {tr_rst, tr_td, tr_done}, {e_rst, e_td, e_done}); end
        checks++; if (tr_busy !== e_busy) begin errors++; $display("FAIL period0_busy: got %h want %h", tr_busy, e_busy); end
        checks++; if ({tr_conf0, tr_conf_chg} !== {exp_conf, 1'b0}) begin errors++; $display("FAIL period0_conf: got %h/%b want %h/0", tr_conf0, tr_conf_chg, exp_conf); end
    endtask

    task automatic test_zero_iter();
        program_cfg(3, 3, 3, 0, 3, 2, 5, 4, 2);
        build_exp(1, 1, 1'b1);
        trace(4, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done, tr_busy} !== {e_rst, e_td, e_done, e_busy}) begin errors++; $display("FAIL zero_iter_trace: got %h want %h", {tr_rst, tr_td, tr_done, tr_busy}, {e_rst, e_td, e_done, e_busy}); end
        checks++; if (tr_conf0 !== exp_conf) begin errors++; $display("FAIL zero_iter_conf: got %h want %h", tr_conf0, exp_conf); end
    endtask

    task automatic test_abort();
        int n_td, n_done, n_busy, n_rst;
        program_cfg(1, 2, 3, 4, 3, 2, 5, 5, 1);
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 5; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (yolo_rst !== 1'b1) begin errors++; $display("FAIL abort_yolo_rst: got %b want 1", yolo_rst); end
        checks++; if (yolo_addrgen_rst !== 1'b1) begin errors++; $display("FAIL abort_agen: got %b want 1", yolo_addrgen_rst); end
        checks++; if ({tile_done, done} !== 2'b00) begin errors++; $display("FAIL abort_pulses: got %b want 00", {tile_done, done}); end
        step();
        checks++; if ({yolo_rst, yolo_addrgen_rst} !== 2'b00) begin errors++; $display("FAIL abort_release: got %b want 00", {yolo_rst, yolo_addrgen_rst}); end
        n_td = 0; n_done = 0; n_busy = 0; n_rst = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            n_td += int'(tile_done);
            n_done += int'(done);
            n_busy += int'(busy);
            n_rst += int'(yolo_rst);
        end
        checks++; if ({n_td, n_done, n_busy, n_rst} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL abort_quiet: td=%0d done=%0d busy=%0d rst=%0d want all 0", n_td, n_done, n_busy, n_rst); end
    endtask

    task automatic test_back_to_back();
        program_cfg(2, 2, 2, 1, 1, 0, 0, 0, 1);
        build_exp(8, 1, 1'b0);  // L = 0 + 1 + 5 = 6; DONE at 8, IDLE at 9, next INIT at 10
        e_rst  = e_rst  | (e_rst  << 10);
        e_td   = e_td   | (e_td   << 10);
        e_done = e_done | (e_done << 10);
        e_busy = e_busy | (e_busy << 10);
        trace(20, 1'b1);
        checks++; if ({tr_rst, tr_td, tr_done} !== {e_rst, e_td, e_done}) begin errors++; $display("FAIL b2b_pulses: got %h want %h", {tr_rst, tr_td, tr_done}, {e_rst, e_td, e_done}); end
        checks++; if (tr_busy !== e_busy) begin errors++; $display("FAIL b2b_busy: got %h want %h", tr_busy, e_busy); end
    endtask

    task automatic test_shadow_isolation();
        logic [`YOLO_CONF_BITS-1:0] old_conf;
        int td_at, done_at, rst_seen;
        program_cfg(1, 2, 3, 4, 3, 2, 5, 5, 1);
        old_conf = exp_conf;
        run = 1'b1;
        step();
        run = 1'b0;
        step(); step(); step();
        cfg_addr = 4'd3; cfg_wdata = 32'd7; cfg_we = 1'b1; run = 1'b1;
        step();
        cfg_we = 1'b0; run = 1'b0;
        checks++; if (yolo_conf !== old_conf) begin errors++; $display("FAIL iso_conf_midrun: got %h want %h", yolo_conf, old_conf); end
        checks++; if ({busy, yolo_rst} !== 2'b10) begin errors++; $display("FAIL iso_run_ignored: busy/yolo_rst got %b want 10", {busy, yolo_rst}); end
        td_at = -1; done_at = -1; rst_seen = 0;
        for (int c = 5; c <= 22; c++) begin
            step();
            if (tile_done) td_at = c;
            if (done) done_at = c;
            rst_seen += int'(yolo_rst);
        end
        checks++; if ({td_at, done_at, rst_seen} !== {32'd20, 32'd21, 32'd0}) begin errors++; $display("FAIL iso_first_layer: td@%0d done@%0d rst=%0d want 20 21 0", td_at, done_at, rst_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iso_idle: got %b want 0", busy); end
        exp_conf = mk_conf(1, 2, 3, 7, 3, 2, 5, 5);
        build_exp(30, 1, 1'b0);  // L = 2 + 7*3 + 5 = 28
        trace(34, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done, tr_busy} !== {e_rst, e_td, e_done, e_busy}) begin errors++; $display("FAIL iso_iter7_trace: got %h want %h", {tr_rst, tr_td, tr_done, tr_busy}, {e_rst, e_td, e_done, e_busy}); end
        checks++; if (tr_conf0 !== exp_conf) begin errors++; $display("FAIL iso_iter7_conf: got %h want %h", tr_conf0, exp_conf); end
        // Same-cycle write and run: the copy must still see iterations 7.
        cfg_addr = 4'd3; cfg_wdata = 32'd2; cfg_we = 1'b1;
        trace(34, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done, tr_busy} !== {e_rst, e_td, e_done, e_busy}) begin errors++; $display("FAIL iso_same_cycle_trace: got %h want %h", {tr_rst, tr_td, tr_done, tr_busy}, {e_rst, e_td, e_done, e_busy}); end
        checks++; if (tr_conf0 !== exp_conf) begin errors++; $display("FAIL iso_same_cycle_conf: got %h want %h", tr_conf0, exp_conf); end
        exp_conf = mk_conf(1, 2, 3, 2, 3, 2, 5, 5);
        build_exp(15, 1, 1'b0);  // L = 2 + 2*3 + 5 = 13
        trace(18, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done, tr_busy} !== {e_rst, e_td, e_done, e_busy}) begin errors++; $display("FAIL iso_iter2_trace: got %h want %h", {tr_rst, tr_td, tr_done, tr_busy}, {e_rst, e_td, e_done, e_busy}); end
        checks++; if (tr_conf0 !== exp_conf) begin errors++; $display("FAIL iso_iter2_conf: got %h want %h", tr_conf0, exp_conf); end
    endtask

    task automatic test_reset_mid();
        program_cfg(1, 2, 3, 4, 3, 2, 5, 5, 2);
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        checks++; if ({busy, yolo_rst, tile_done, done, yolo_addrgen_rst} !== 5'b00001) begin errors++; $display("FAIL midrst_outputs: got %b want 00001", {busy, yolo_rst, tile_done, done, yolo_addrgen_rst}); end
        checks++; if (yolo_conf !== '0) begin errors++; $display("FAIL midrst_conf: got %h want 0", yolo_conf); end
        rst = 1'b0;
        step();
        build_exp(1, 1, 1'b1);
        trace(3, 1'b0);
        checks++; if ({tr_rst, tr_td, tr_done, tr_busy} !== {e_rst, e_td, e_done, e_busy}) begin errors++; $display("FAIL midrst_shadow_cleared: got %h want %h", {tr_rst, tr_td, tr_done, tr_busy}, {e_rst, e_td, e_done, e_busy}); end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; run = 1'b0; abort = 1'b0;
        exp_conf = '0;
        test_reset();
        test_single_tile();
        test_repeat();
        test_repeat_zero();
        test_period_zero();
        test_zero_iter();
        test_abort();
        test_back_to_back();
        test_shadow_isolation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
